// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage constants and the next-PC selector type.
// Default widths and reset/step/halt values used by the fetch unit and its PC block.
package instruction_fetch_unit_pkg;

  localparam int          ADDR_W_DEF     = 32;
  localparam int          DATA_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'd0;
  localparam logic [31:0] PC_STEP_DEF    = 32'd4;
  localparam logic [31:0] HALT_WORD_DEF  = 32'd0;
  // ARM reads PC as the instruction address plus two words.
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INCR   = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_unit_pc.sv
// Program counter register with its next-PC mux (hold / increment / word-aligned branch).
// The new PC is visible on pc_o one clock after the select is applied.
module instruction_fetch_unit_pc
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (sel_i)
      PC_BRANCH: pc_d = {target_i[ADDR_W-1:2], 2'b00};
      PC_INCR:   pc_d = pc_q + PC_STEP;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the PC onto the instruction memory and captures the word into IF/ID.
// Branch beats stall beats halt; a fetched HALT_WORD freezes fetching until a branch.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(PC_STEP_DEF),
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus8,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] RD_OFS = ADDR_W'(PC_READ_OFFSET);

  logic [ADDR_W-1:0] pc;
  pc_sel_e           pc_sel;
  logic              capture;
  logic              hit_halt;

  logic              valid_q,  valid_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] instr_q,  instr_d;
  logic [ADDR_W-1:0] ipc_q,    ipc_d;
  logic [ADDR_W-1:0] p8_q,     p8_d;

  instruction_fetch_unit_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .sel_i    (pc_sel),
    .target_i (branch_target),
    .pc_o     (pc)
  );

  assign hit_halt = (imem_data == HALT_WORD);

  always_comb begin
    pc_sel   = PC_HOLD;
    capture  = 1'b0;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (branch_taken) begin
      pc_sel   = PC_BRANCH;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (stall) begin
      pc_sel = PC_HOLD;
    end else if (halted_q) begin
      valid_d = 1'b0;
    end else if (hit_halt) begin
      // PC stays parked on the halt word so imem_addr points at it.
      halted_d = 1'b1;
      valid_d  = 1'b0;
    end else begin
      pc_sel  = PC_INCR;
      capture = 1'b1;
      valid_d = 1'b1;
    end
  end

  // Bubbles leave the payload untouched; consumers qualify with if_id_valid.
  assign instr_d = capture ? imem_data   : instr_q;
  assign ipc_d   = capture ? pc          : ipc_q;
  assign p8_d    = capture ? pc + RD_OFS : p8_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      p8_q     <= RD_OFS;
    end else begin
      valid_q  <= valid_d;
      halted_q <= halted_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      p8_q     <= p8_d;
    end
  end

  assign imem_addr      = pc;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus8 = p8_q;
  assign halted         = halted_q;

endmodule
